// File: rtl/hazard_fwd_unit.sv
// Hazard detection and EX operand forwarding from a private shadow pipeline of destination tags.
// Optional macro RF_WB_HOLD_EN adds a post-WB HOLD stage that drives select 11.
module hazard_fwd_unit #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              ex_branch_taken,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              stall,
    output logic              bubble,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [1:0] SEL_RF   = 2'b00;
    localparam logic [1:0] SEL_WB   = 2'b01;
    localparam logic [1:0] SEL_MEM  = 2'b10;
    localparam logic [1:0] SEL_HOLD = 2'b11;

    // Producer tag; the load flag lives beside it only where it is consulted (EX, MEM).
    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic [REG_AW-1:0] rd;
    } tag_t;

    typedef struct packed {
        tag_t              t;
        logic              mem_read;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              use_rs1;
        logic              use_rs2;
    } ex_tag_t;

    ex_tag_t ex_q;
    tag_t    mem_q;
    logic    mem_load_q;
    tag_t    wb_q;
`ifdef RF_WB_HOLD_EN
    tag_t    hold_q;
`endif

    function automatic logic produces(input tag_t s, input logic [REG_AW-1:0] r);
        return s.valid & s.reg_write & (s.rd != '0) & (s.rd == r);
    endfunction

    // Youngest producer wins; a load still in MEM has no data to forward yet.
    function automatic logic [1:0] pick_sel(input logic [REG_AW-1:0] r, input logic use_bit);
        logic [1:0] sel;
        sel = SEL_RF;
        if (ex_q.t.valid && use_bit) begin
            if (produces(mem_q, r) && !mem_load_q)
                sel = SEL_MEM;
            else if (produces(wb_q, r))
                sel = SEL_WB;
`ifdef RF_WB_HOLD_EN
            else if (produces(hold_q, r))
                sel = SEL_HOLD;
`endif
        end
        return sel;
    endfunction

    always_comb begin
        fwd_a_sel = pick_sel(ex_q.rs1, ex_q.use_rs1);
        fwd_b_sel = pick_sel(ex_q.rs2, ex_q.use_rs2);
    end

    // Load-use detection; a taken branch flushes the consumer instead of stalling it.
    always_comb begin
        stall  = id_valid & ex_q.t.valid & ex_q.mem_read & (ex_q.t.rd != '0)
               & ((id_use_rs1 & (ex_q.t.rd == id_rs1)) | (id_use_rs2 & (ex_q.t.rd == id_rs2)))
               & ~ex_branch_taken;
        bubble = stall | ex_branch_taken;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q       <= '0;
            mem_q      <= '0;
            mem_load_q <= 1'b0;
            wb_q       <= '0;
`ifdef RF_WB_HOLD_EN
            hold_q     <= '0;
`endif
        end else begin
`ifdef RF_WB_HOLD_EN
            hold_q     <= wb_q;
`endif
            wb_q       <= mem_q;
            mem_q      <= ex_q.t;
            mem_load_q <= ex_q.mem_read;
            if (bubble) begin
                ex_q <= '0;
            end else begin
                ex_q.t.valid     <= id_valid;
                ex_q.t.reg_write <= id_reg_write;
                ex_q.t.rd        <= id_rd;
                ex_q.mem_read    <= id_mem_read;
                ex_q.rs1         <= id_rs1;
                ex_q.rs2         <= id_rs2;
                ex_q.use_rs1     <= id_use_rs1;
                ex_q.use_rs2     <= id_use_rs2;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_count <= '0;
        else if (stall && (stall_count != '1))
            stall_count <= stall_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: hand-derived cycle table, corner sequences,
// and random stimulus against an instruction-history reference model.
module tb_hazard_fwd_unit;

    localparam int unsigned REG_AW  = 5;
    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;
`ifdef RF_WB_HOLD_EN
    localparam int          MAXAGE   = 3;
    localparam logic [1:0]  HOLD_SEL = 2'b11;
`else
    localparam int          MAXAGE   = 2;
    localparam logic [1:0]  HOLD_SEL = 2'b00;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
    logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
    logic              ex_branch_taken;
    logic [1:0]        fwd_a_sel, fwd_b_sel;
    logic              stall, bubble;
    logic [CNT_W-1:0]  stall_count;

    hazard_fwd_unit #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .ex_branch_taken(ex_branch_taken),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall(stall), .bubble(bubble), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } ins_t;

    typedef struct {
        ins_t       id;
        logic       br;
        logic [1:0] ea;
        logic [1:0] eb;
        logic       es;
        logic       ebub;
        int         ecnt;
    } vec_t;

    vec_t tbl[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: hist[0] is the instruction in EX, hist[k] the one issued k cycles earlier.
    ins_t hist [0:3];
    int   mcnt;

    function automatic ins_t mk(input logic v, input int rs1, input int rs2, input logic u1,
                                input logic u2, input int rd, input logic rw, input logic mr);
        ins_t i;
        i.v = v; i.rs1 = 5'(rs1); i.rs2 = 5'(rs2); i.u1 = u1; i.u2 = u2;
        i.rd = 5'(rd); i.rw = rw; i.mr = mr;
        return i;
    endfunction

    task automatic tv(input ins_t i, input logic br, input logic [1:0] a, input logic [1:0] b,
                      input logic s, input logic bb, input int c);
        vec_t v;
        v.id = i; v.br = br; v.ea = a; v.eb = b; v.es = s; v.ebub = bb; v.ecnt = c;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic logic [1:0] age_code(input int k);
        case (k)
            1:       return 2'b10;
            2:       return 2'b01;
            3:       return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] model_sel(input bit is_b);
        ins_t       c;
        logic [4:0] r;
        logic       u;
        c = hist[0];
        r = is_b ? c.rs2 : c.rs1;
        u = is_b ? c.u2 : c.u1;
        if (!c.v || !u) return 2'b00;
        for (int k = 1; k <= MAXAGE; k++) begin
            if (hist[k].v && hist[k].rw && hist[k].rd != 0 && hist[k].rd == r) begin
                if (!(k == 1 && hist[k].mr)) return age_code(k);
            end
        end
        return 2'b00;
    endfunction

    function automatic logic model_stall(input ins_t i, input logic br);
        ins_t e;
        e = hist[0];
        return i.v && e.v && e.mr && e.rd != 0 &&
               ((i.u1 && e.rd == i.rs1) || (i.u2 && e.rd == i.rs2)) && !br;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 4; k++) hist[k] = '0;
        mcnt = 0;
    endtask

    task automatic drive(input ins_t i, input logic br);
        id_valid = i.v; id_rs1 = i.rs1; id_rs2 = i.rs2; id_use_rs1 = i.u1; id_use_rs2 = i.u2;
        id_rd = i.rd; id_reg_write = i.rw; id_mem_read = i.mr; ex_branch_taken = br;
    endtask

    task automatic apply(input ins_t i, input logic br);
        @(negedge clk);
        drive(i, br);
        #1;
    endtask

    // Advance one clock edge and move the model along with it.
    task automatic tick(input ins_t i, input logic br);
        logic s;
        @(posedge clk);
        s = model_stall(i, br);
        if (s && mcnt < CNT_MAX) mcnt++;
        for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = (s || br) ? '0 : i;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_a"},   fwd_a_sel,   model_sel(1'b0));
        chk({tag, "_b"},   fwd_b_sel,   model_sel(1'b1));
        chk({tag, "_st"},  stall,       model_stall({id_valid, id_rs1, id_rs2, id_use_rs1,
                                                     id_use_rs2, id_rd, id_reg_write,
                                                     id_mem_read}, ex_branch_taken));
        chk({tag, "_bub"}, bubble,      model_stall({id_valid, id_rs1, id_rs2, id_use_rs1,
                                                     id_use_rs2, id_rd, id_reg_write,
                                                     id_mem_read}, ex_branch_taken)
                                        | ex_branch_taken);
        chk({tag, "_cnt"}, stall_count, mcnt);
    endtask

    initial begin
        ins_t nop, lw7, dep7, i;
        logic br;
        nop  = '0;
        lw7  = mk(1, 1, 0, 1, 0, 7, 1, 1);
        dep7 = mk(1, 7, 1, 1, 1, 8, 1, 0);

        // ALU chain: gap 0, 1, 2
        tv(mk(1, 1, 2, 1, 1, 5, 1, 0), 0, 0, 0, 0, 0, 0);
        tv(mk(1, 5, 5, 1, 1, 6, 1, 0), 0, 0, 0, 0, 0, -1);
        tv(nop, 0, 2'b10, 2'b10, 0, 0, -1);
        tv(mk(1, 1, 2, 1, 1, 10, 1, 0), 0, 0, 0, 0, 0, -1);
        tv(nop, 0, 0, 0, 0, 0, -1);
        tv(mk(1, 10, 10, 1, 1, 11, 1, 0), 0, 0, 0, 0, 0, -1);
        tv(nop, 0, 2'b01, 2'b01, 0, 0, -1);
        tv(mk(1, 1, 2, 1, 1, 12, 1, 0), 0, 0, 0, 0, 0, -1);
        tv(nop, 0, 0, 0, 0, 0, -1);
        tv(nop, 0, 0, 0, 0, 0, -1);
        tv(mk(1, 12, 12, 1, 1, 13, 1, 0), 0, 0, 0, 0, 0, -1);
        tv(nop, 0, HOLD_SEL, HOLD_SEL, 0, 0, -1);
        // Load-use: one stall, then WB forward
        tv(lw7, 0, 0, 0, 0, 0, -1);
        tv(dep7, 0, 0, 0, 1, 1, 0);
        tv(dep7, 0, 0, 0, 0, 0, 1);
        tv(nop, 0, 2'b01, 2'b00, 0, 0, 1);
        // x0 destination and cleared use bits
        tv(mk(1, 1, 0, 1, 0, 0, 1, 0), 0, 0, 0, 0, 0, -1);
        tv(mk(1, 0, 3, 1, 1, 14, 1, 0), 0, 0, 0, 0, 0, -1);
        tv(mk(1, 2, 14, 1, 0, 15, 1, 0), 0, 0, 0, 0, 0, -1);
        tv(nop, 0, 0, 0, 0, 0, -1);
        tv(mk(1, 1, 0, 1, 0, 0, 1, 1), 0, 0, 0, 0, 0, -1);
        tv(mk(1, 0, 0, 1, 0, 16, 1, 0), 0, 0, 0, 0, 0, -1);
        tv(nop, 0, 0, 0, 0, 0, -1);
        tv(mk(1, 1, 0, 1, 0, 17, 1, 1), 0, 0, 0, 0, 0, -1);
        tv(mk(1, 2, 17, 1, 0, 18, 1, 0), 0, 0, 0, 0, 0, -1);
        tv(nop, 0, 0, 0, 0, 0, -1);
        // Flush dominates stall
        tv(mk(1, 1, 0, 1, 0, 19, 1, 1), 0, 0, 0, 0, 0, -1);
        tv(mk(1, 19, 0, 1, 0, 20, 1, 0), 1, 0, 0, 0, 1, 1);
        tv(nop, 0, 0, 0, 0, 0, -1);
        tv(nop, 0, 0, 0, 0, 0, 1);
        // Youngest producer wins
        tv(mk(1, 1, 2, 1, 1, 9, 1, 0), 0, 0, 0, 0, 0, -1);
        tv(mk(1, 3, 4, 1, 1, 9, 1, 0), 0, 0, 0, 0, 0, -1);
        tv(mk(1, 9, 9, 1, 1, 21, 1, 0), 0, 0, 0, 0, 0, -1);
        tv(nop, 0, 2'b10, 2'b10, 0, 0, -1);

        rst = 1'b1;
        drive(nop, 1'b0);
        model_clear();
        #12;
        chk("rst_a", fwd_a_sel, 0);
        chk("rst_b", fwd_b_sel, 0);
        chk("rst_stall", stall, 0);
        chk("rst_bubble", bubble, 0);
        chk("rst_cnt", stall_count, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[k]) begin
            apply(tbl[k].id, tbl[k].br);
            chk($sformatf("tbl%0d_a", k), fwd_a_sel, tbl[k].ea);
            chk($sformatf("tbl%0d_b", k), fwd_b_sel, tbl[k].eb);
            chk($sformatf("tbl%0d_stall", k), stall, tbl[k].es);
            chk($sformatf("tbl%0d_bubble", k), bubble, tbl[k].ebub);
            if (tbl[k].ecnt >= 0) chk($sformatf("tbl%0d_cnt", k), stall_count, tbl[k].ecnt);
            tick(tbl[k].id, tbl[k].br);
        end

        // Reset mid-stream with a live load-use hazard and producers in flight
        apply(mk(1, 1, 2, 1, 1, 5, 1, 0), 0); tick(mk(1, 1, 2, 1, 1, 5, 1, 0), 0);
        apply(lw7, 0); tick(lw7, 0);
        apply(dep7, 0);
        chk("pre_rst_stall", stall, 1);
        rst = 1'b1;
        #1;
        model_clear();
        chk("mid_rst_a", fwd_a_sel, 0);
        chk("mid_rst_b", fwd_b_sel, 0);
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_bubble", bubble, 0);
        chk("mid_rst_cnt", stall_count, 0);
        @(negedge clk);
        rst = 1'b0;
        apply(mk(1, 5, 5, 1, 1, 6, 1, 0), 0); tick(mk(1, 5, 5, 1, 1, 6, 1, 0), 0);
        apply(nop, 0);
        chk("post_rst_a", fwd_a_sel, 0);
        chk("post_rst_b", fwd_b_sel, 0);
        tick(nop, 0);

        // Drive the stall counter past its maximum
        for (int n = 0; n < CNT_MAX + 3; n++) begin
            apply(lw7, 0); tick(lw7, 0);
            apply(dep7, 0);
            chk("sat_stall", stall, 1);
            tick(dep7, 0);
            apply(nop, 0); tick(nop, 0);
        end
        apply(nop, 0);
        chk("sat_cnt", stall_count, CNT_MAX);
        tick(nop, 0);
        apply(lw7, 0); tick(lw7, 0);
        apply(dep7, 0); tick(dep7, 0);
        apply(nop, 0);
        chk("sat_hold", stall_count, CNT_MAX);
        tick(nop, 0);

        // Random traffic against the model; small register range to provoke hazards
        for (int n = 0; n < 2000; n++) begin
            i.v  = ($urandom_range(0, 7) != 0);
            i.rs1 = 5'($urandom_range(0, 7));
            i.rs2 = 5'($urandom_range(0, 7));
            i.u1 = 1'($urandom_range(0, 1));
            i.u2 = 1'($urandom_range(0, 1));
            i.rd = 5'($urandom_range(0, 7));
            i.rw = ($urandom_range(0, 4) != 0);
            i.mr = ($urandom_range(0, 2) == 0);
            br   = ($urandom_range(0, 9) == 0);
            apply(i, br);
            check_model("rnd");
            tick(i, br);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_unit.md
# hazard_fwd_unit

Tracks destination-register tags of in-flight instructions in a private shadow pipeline (EX, MEM, WB, optional HOLD) and drives the 2-bit select of both EX-stage operand 4:1 muxes. Also raises the load-use stall and inserts the ID/EX bubble. Sits between decode and the EX operand muxes and produces their select lines.

## Interface
Parameters:
- REG_AW, 5, register-address width
- CNT_W, 16, width of stall performance counter

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs1, id_rs2  in  REG_AW  ID source registers
- id_use_rs1, id_use_rs2  in  1  instruction actually reads rs1/rs2
- id_rd  in  REG_AW  ID destination register
- id_reg_write  in  1  ID instruction writes rd
- id_mem_read  in  1  ID instruction is a load
- ex_branch_taken  in  1  EX resolved a taken branch/jump; flush
- fwd_a_sel, fwd_b_sel  out  2  operand-mux selects for rs1/rs2 of EX instruction
- stall  out  1  freeze PC and IF/ID this cycle
- bubble  out  1  load zeros/NOP into ID/EX next edge
- stall_count  out  CNT_W  saturating count of stall cycles

## Operation
- Select encoding (matches mux wiring): 00 register-file value; 01 WB result; 10 MEM-stage ALU result; 11 HOLD result (post-WB, see Configuration).
- Tag per stage: valid, rd, reg_write, mem_read; EX tag also holds rs1, rs2, use_rs1, use_rs2.
- Match(stage, r) = stage.valid & stage.reg_write & stage.rd != 0 & stage.rd == r & use bit set.
- fwd_a_sel priority: MEM match on EX.rs1 and !MEM.mem_read → 10; else WB match → 01; else HOLD match → 11; else 00. fwd_b_sel identical on EX.rs2. Youngest producer wins.
- stall = id_valid & EX.valid & EX.mem_read & EX.rd != 0 & ((id_use_rs1 & EX.rd == id_rs1) | (id_use_rs2 & EX.rd == id_rs2)) & !ex_branch_taken.
- bubble = stall | ex_branch_taken.
- Each edge: HOLD←WB, WB←MEM, MEM←EX; EX←ID fields with valid=id_valid, or EX.valid←0 when bubble.
- Flush dominates stall: on ex_branch_taken, stall is 0, bubble is 1, younger ID instruction is discarded.
- rd = x0 never forwards, never stalls.
- stall_count increments on each edge with stall=1, saturates at 2^CNT_W−1.

## Timing
- Reset (async, immediate): all tags valid=0, stall_count=0; hence fwd_a_sel=fwd_b_sel=00, stall=0, bubble=0.
- Reset mid-operation drops all in-flight tags; first post-reset instruction sees 00 selects.
- fwd_*_sel: combinational from registered tags only; valid from start of the cycle the instruction is in EX.
- stall/bubble: combinational from ID inputs and EX tag; same-cycle response, exactly one stall cycle per load-use hazard.
- Latency: consumer directly after producer → 10; gap 1 → 01; gap 2 → 11 (macro on) or 00; load then dependent → 1 stall, then 01.

## Configuration
- RF_WB_HOLD_EN defined: HOLD stage present; select 11 produced when post-WB instruction matches (register file without write-through bypass).
- Undefined: no HOLD stage; 11 never produced; gap-2 dependence selects 00 (register file bypasses internally).

## Test plan
- Reset: assert rst mid-stream with tags live → all outputs 0 immediately, stall_count=0.
- ALU chain: add x5 then sub x6,x5,x5 back-to-back → fwd_a_sel=fwd_b_sel=10 in sub's EX cycle; insert 1 NOP → 01; 2 NOPs → 11 (macro on) / 00 (off).
- Load-use: lw x7 then add x8,x7,x1 → stall=1, bubble=1 for one cycle, then add in EX with fwd_a_sel=01, fwd_b_sel=00, stall_count=1.
- x0 and use bits: addi x0 then use x0; use_rs2=0 with rs2 match → selects 00, no stall.
- Flush vs stall: load-use hazard with ex_branch_taken=1 same cycle → stall=0, bubble=1, stall_count unchanged.
- Priority: MEM and WB both write x9, EX reads x9 → 10; stall_count at max stays saturated.
